// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef logic master_id_t;

  localparam master_id_t MST_BOOT = 1'b0;
  localparam master_id_t MST_CPU  = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Response watchdog: counts enabled cycles and flags when TIMEOUT-1 is reached.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Clear wins over enable so a completing transaction leaves the count at zero.
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_port_arbiter.sv
// Two-master round-robin arbiter for the instruction-memory port with boot lock and watchdog.
// Optional saturating grant/timeout statistics when IMEM_ARB_STATS_EN is defined.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            boot_lock,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_be,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_be,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]     stat_gnt0,
  output logic [15:0]     stat_gnt1,
  output logic [7:0]      stat_tout
`endif
);

  arb_state_e r_state, w_state_nxt;
  master_id_t w_sel_id;
  master_id_t r_owner, w_owner_nxt;
  master_id_t r_rr_ptr, w_rr_nxt;
  master_id_t r_hold_id, w_hold_id_nxt;
  logic       r_hold_vld, w_hold_vld_nxt;
  logic       w_sel_vld;
  logic       w_mem_req;
  logic       w_hs;
  logic       w_rsp_vld, w_rsp_err;
  logic [DW-1:0] w_rsp_data;
  logic       w_ctr_clr, w_ctr_en, w_expired;

  logic          r_m0_rvalid, r_m0_err, r_m1_rvalid, r_m1_err;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  // A stalled request keeps its master selected until memory grants it.
  always_comb begin
    w_sel_id  = MST_BOOT;
    w_sel_vld = 1'b0;
    if (r_hold_vld) begin
      w_sel_id  = r_hold_id;
      w_sel_vld = 1'b1;
    end else if (boot_lock) begin
      w_sel_id  = MST_BOOT;
      w_sel_vld = m0_req;
    end else if (m0_req && m1_req) begin
      w_sel_id  = r_rr_ptr;
      w_sel_vld = 1'b1;
    end else if (m1_req) begin
      w_sel_id  = MST_CPU;
      w_sel_vld = 1'b1;
    end else if (m0_req) begin
      w_sel_id  = MST_BOOT;
      w_sel_vld = 1'b1;
    end
  end

  assign w_mem_req = !Rst && (r_state == ARB_IDLE) && w_sel_vld &&
                     ((w_sel_id == MST_CPU) ? m1_req : m0_req);
  assign w_hs      = w_mem_req && mem_gnt;

  assign mem_req   = w_mem_req;
  assign mem_we    = (w_sel_id == MST_CPU) ? m1_we    : m0_we;
  assign mem_addr  = (w_sel_id == MST_CPU) ? m1_addr  : m0_addr;
  assign mem_be    = (w_sel_id == MST_CPU) ? m1_be    : m0_be;
  assign mem_wdata = (w_sel_id == MST_CPU) ? m1_wdata : m0_wdata;
  assign m0_gnt    = w_hs && (w_sel_id == MST_BOOT);
  assign m1_gnt    = w_hs && (w_sel_id == MST_CPU);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The watchdog starts counting at the handshake so expiry lands TIMEOUT cycles after grant.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_nxt       = r_rr_ptr;
    w_hold_vld_nxt = r_hold_vld;
    w_hold_id_nxt  = r_hold_id;
    w_rsp_vld      = 1'b0;
    w_rsp_err      = 1'b0;
    w_rsp_data     = '0;
    w_ctr_clr      = 1'b0;
    w_ctr_en       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_hs) begin
          w_owner_nxt    = w_sel_id;
          w_hold_vld_nxt = 1'b0;
          w_rr_nxt       = ~w_sel_id;
          w_ctr_en       = 1'b1;
          w_state_nxt    = ARB_WAIT;
        end else if (w_mem_req) begin
          w_hold_vld_nxt = 1'b1;
          w_hold_id_nxt  = w_sel_id;
        end
      end
      ARB_WAIT: begin
        w_ctr_en = 1'b1;
        if (mem_rvalid) begin
          w_rsp_vld   = 1'b1;
          w_rsp_data  = mem_rdata;
          w_ctr_clr   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end else if (w_expired) begin
          w_rsp_vld   = 1'b1;
          w_rsp_err   = 1'b1;
          w_ctr_clr   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_owner     <= MST_BOOT;
      r_rr_ptr    <= MST_BOOT;
      r_hold_vld  <= 1'b0;
      r_hold_id   <= MST_BOOT;
      r_m0_rvalid <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rvalid <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      r_hold_id   <= w_hold_id_nxt;
      r_m0_rvalid <= w_rsp_vld && (r_owner == MST_BOOT);
      r_m0_err    <= w_rsp_vld && w_rsp_err && (r_owner == MST_BOOT);
      r_m1_rvalid <= w_rsp_vld && (r_owner == MST_CPU);
      r_m1_err    <= w_rsp_vld && w_rsp_err && (r_owner == MST_CPU);
      // Non-owner read data holds its previous value.
      if (w_rsp_vld && (r_owner == MST_BOOT)) begin
        r_m0_rdata <= w_rsp_data;
      end
      if (w_rsp_vld && (r_owner == MST_CPU)) begin
        r_m1_rdata <= w_rsp_data;
      end
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m0_err    = r_m0_err;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rvalid = r_m1_rvalid;
  assign m1_err    = r_m1_err;
  assign m1_rdata  = r_m1_rdata;

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tout (
    .Clk     (Clk),
    .Rst     (Rst),
    .clr     (w_ctr_clr),
    .en      (w_ctr_en),
    .expired (w_expired)
  );

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] r_stat_gnt0, r_stat_gnt1;
  logic [7:0]  r_stat_tout;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stat_gnt0 <= '0;
      r_stat_gnt1 <= '0;
      r_stat_tout <= '0;
    end else begin
      if (m0_gnt && (r_stat_gnt0 != 16'hFFFF)) r_stat_gnt0 <= r_stat_gnt0 + 16'd1;
      if (m1_gnt && (r_stat_gnt1 != 16'hFFFF)) r_stat_gnt1 <= r_stat_gnt1 + 16'd1;
      if (w_rsp_vld && w_rsp_err && (r_stat_tout != 8'hFF)) r_stat_tout <= r_stat_tout + 8'd1;
    end
  end

  assign stat_gnt0 = r_stat_gnt0;
  assign stat_gnt1 = r_stat_gnt1;
  assign stat_tout = r_stat_tout;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: vector table, round-robin/boot-lock runs,
// request hold under boot_lock, and reset abort; responses checked through a scoreboard.
module tb_imem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] K  = 32'h5A5A_0000;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          boot_lock;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_be;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_be;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0]   stat_gnt0, stat_gnt1;
  logic [7:0]    stat_tout;
`endif

  imem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .Clk(Clk), .Rst(Rst), .boot_lock(boot_lock),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_tout(stat_tout)
`endif
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          gnt_dly;
    int          rv_dly;     // 0: memory never answers
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;    // grant cycle to visible rvalid
  } vec_t;

  typedef struct {
    logic        mst;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] shadow0 = '0;
  logic [31:0] shadow1 = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  // Sample at the falling edge and retire any response against the scoreboard.
  task automatic sample();
    sb_t e;
    @(negedge Clk);
    if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
      chk("rsp_missing", 64'(cyc), 64'(sbq[0].cyc));
      e = sbq.pop_front();
    end
    if (m0_rvalid || m1_rvalid) begin
      if (sbq.size() == 0) begin
        chk("stray_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("rsp_owner", 64'({m1_rvalid, m0_rvalid}), e.mst ? 64'(2) : 64'(1));
        chk("rsp_err", 64'(e.mst ? m1_err : m0_err), 64'(e.err));
        chk("rsp_rdata", 64'(e.mst ? m1_rdata : m0_rdata), 64'(e.rdata));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("held_rdata", 64'(e.mst ? m0_rdata : m1_rdata), 64'(e.mst ? shadow0 : shadow1));
        if (e.mst) shadow1 = e.rdata;
        else       shadow0 = e.rdata;
      end
    end
  endtask

  task automatic idle_inputs();
    boot_lock = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst = 1'b1;
    next_cyc();
    next_cyc();
    Rst = 1'b0;
    sbq.delete();
    shadow0 = '0;
    shadow1 = '0;
  endtask

  task automatic run_vec(input vec_t v);
    bit got = 1'b0;
    m0_req = !v.mst; m1_req = v.mst;
    if (v.mst) begin
      m1_we = v.we;  m1_addr = v.addr;  m1_be = v.be;  m1_wdata = v.wdata;
      m0_we = !v.we; m0_addr = ~v.addr; m0_be = ~v.be; m0_wdata = ~v.wdata;
    end else begin
      m0_we = v.we;  m0_addr = v.addr;  m0_be = v.be;  m0_wdata = v.wdata;
      m1_we = !v.we; m1_addr = ~v.addr; m1_be = ~v.be; m1_wdata = ~v.wdata;
    end
    for (int c = 0; c < 16 && !got; c++) begin
      mem_gnt = (c >= v.gnt_dly);
      sample();
      chk("fwd_addr", 64'(mem_addr), 64'(v.addr));
      if (c < v.gnt_dly) begin
        chk("hold_gnt", 64'({m1_gnt, m0_gnt}), 64'(0));
      end else begin
        chk("fwd_ctrl", 64'({mem_req, mem_we, mem_be}), 64'({1'b1, v.we, v.be}));
        chk("fwd_wdata", 64'(mem_wdata), 64'(v.wdata));
        chk("grant", 64'({m1_gnt, m0_gnt}), v.mst ? 64'(2) : 64'(1));
        sbq.push_back('{v.mst, v.exp_err, v.exp_rdata, cyc + v.exp_lat});
        got = 1'b1;
      end
      next_cyc();
    end
    chk("grant_seen", 64'(got), 64'(1));
    m0_req = 1'b0; m1_req = 1'b0; mem_gnt = 1'b1;
    for (int k = 1; k <= 12 && sbq.size() > 0; k++) begin
      mem_rvalid = (k == v.rv_dly);
      mem_rdata  = (k == v.rv_dly) ? v.mdata : (32'hBAD0_0000 | 32'(k));
      sample();
      if (k == 1) chk("wait_quiet", 64'({mem_req, m1_gnt, m0_gnt}), 64'(0));
      next_cyc();
    end
    // Late/stray response while idle must be dropped.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    sample();
    next_cyc();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    sample();
    chk("stray_drop", 64'({m1_rvalid, m0_rvalid}), 64'(0));
    next_cyc();
  endtask

  // Both masters request continuously; memory grants at once and answers a cycle later.
  task automatic auto_run(input int n, input logic lock, input logic first, input logic alt);
    logic        want = first;
    int          grants = 0;
    int          last_g = -1;
    bit          pend = 1'b0;
    logic [31:0] pdata = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1000; m0_be = 4'hF; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_2000; m1_be = 4'hF; m1_wdata = '0;
    boot_lock = lock; mem_gnt = 1'b1;
    for (int c = 0; c < n * 4 + 10 && grants < n; c++) begin
      mem_rvalid = pend; mem_rdata = pdata; pend = 1'b0;
      sample();
      if (m0_gnt || m1_gnt) begin
        chk("rr_grant", 64'({m1_gnt, m0_gnt}), want ? 64'(2) : 64'(1));
        chk("rr_addr", 64'(mem_addr), want ? 64'(32'h2000) : 64'(32'h1000));
        if (last_g >= 0) chk("rr_spacing", 64'(cyc - last_g), 64'(2));
        sbq.push_back('{want, 1'b0, (want ? 32'h2000 : 32'h1000) ^ K, cyc + 2});
        last_g = cyc;
        pend   = 1'b1;
        pdata  = mem_addr ^ K;
        grants++;
        if (alt) want = ~want;
      end else if (last_g >= 0 && cyc == last_g + 1) begin
        chk("wait_no_req", 64'({mem_req, m1_gnt, m0_gnt}), 64'(0));
      end
      next_cyc();
    end
    chk("rr_count", 64'(grants), 64'(n));
    m0_req = 1'b0; m1_req = 1'b0;
    for (int d = 0; d < 4; d++) begin
      mem_rvalid = pend; mem_rdata = pdata; pend = 1'b0;
      sample();
      next_cyc();
    end
    idle_inputs();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h100,  4'b0001, 32'hAAAA_AAAA, 32'h1111_1111, 0, 1, 1'b0, 32'h1111_1111, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h2000, 4'hF,    32'h0,         32'hDEAD_BEEF, 2, 3, 1'b0, 32'hDEAD_BEEF, 4};
    vecs[2] = '{1'b0, 1'b0, 32'h44,   4'hF,    32'h0,         32'h0123_4567, 0, 7, 1'b0, 32'h0123_4567, 8};
    vecs[3] = '{1'b1, 1'b1, 32'h88,   4'b1100, 32'h55AA_55AA, 32'h7777_7777, 1, 0, 1'b1, 32'h0,         8};
    vecs[4] = '{1'b0, 1'b0, 32'h8,    4'b0011, 32'h0,         32'hCAFE_F00D, 0, 6, 1'b0, 32'hCAFE_F00D, 7};
    vecs[5] = '{1'b0, 1'b0, 32'hFC,   4'hF,    32'h0,         32'h9999_9999, 0, 0, 1'b1, 32'h0,         8};

    do_reset();
    sample();
    chk("rst_ctrl", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_req}), 64'(0));
    chk("rst_rdata", 64'({m1_rdata, m0_rdata}), 64'(0));
    next_cyc();

    foreach (vecs[i]) run_vec(vecs[i]);

    do_reset();
    auto_run(6, 1'b0, 1'b0, 1'b1);
    auto_run(10, 1'b1, 1'b0, 1'b0);
    auto_run(2, 1'b0, 1'b1, 1'b1);

    // m1 stalled by memory; m0 and boot_lock arrive meanwhile, m1 still goes first.
    idle_inputs();
    m1_req = 1'b1; m1_addr = 32'h300; m1_be = 4'hF;
    m0_addr = 32'h100; m0_be = 4'hF;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) m0_req = 1'b1;
      if (c == 3) boot_lock = 1'b1;
      mem_gnt = (c == 5);
      sample();
      chk("lock_hold_addr", 64'(mem_addr), 64'(32'h300));
      chk("lock_hold_gnt", 64'({m1_gnt, m0_gnt}), (c == 5) ? 64'(2) : 64'(0));
      if (c == 5) sbq.push_back('{1'b1, 1'b0, 32'h300 ^ K, cyc + 2});
      next_cyc();
    end
    m1_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h300 ^ K;
    sample();
    next_cyc();
    mem_rvalid = 1'b0; m1_req = 1'b1;
    sample();
    chk("lock_next_gnt", 64'({m1_gnt, m0_gnt}), 64'(1));
    chk("lock_next_addr", 64'(mem_addr), 64'(32'h100));
    sbq.push_back('{1'b0, 1'b0, 32'h100 ^ K, cyc + 2});
    next_cyc();
    m0_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h100 ^ K;
    sample();
    next_cyc();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("lock_ignore_m1", 64'({mem_req, m1_gnt}), 64'(0));
      next_cyc();
    end
    idle_inputs();
    next_cyc();

    // Reset while waiting on memory aborts the transaction silently.
    m0_req = 1'b1; m0_addr = 32'h40; m0_be = 4'hF; mem_gnt = 1'b1;
    sample();
    chk("abort_gnt", 64'({m1_gnt, m0_gnt}), 64'(1));
    next_cyc();
    m0_req = 1'b0; mem_gnt = 1'b0;
    sample();
    next_cyc();
    Rst = 1'b1;
    sample();
    chk("abort_in_rst", 64'({m1_rvalid, m0_rvalid, mem_req}), 64'(0));
    next_cyc();
    Rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    sample();
    chk("abort_ctrl", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_req}), 64'(0));
    chk("abort_rdata", 64'({m1_rdata, m0_rdata}), 64'(0));
    next_cyc();
    mem_rvalid = 1'b0;
    sample();
    chk("abort_no_rsp", 64'({m1_rvalid, m0_rvalid}), 64'(0));
    next_cyc();
    shadow0 = '0;
    shadow1 = '0;
    auto_run(2, 1'b0, 1'b0, 1'b1);

    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
